// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
package mem_arbiter_pkg;

    typedef logic [63:0] qword_t;

    typedef enum logic [1:0] {
        MA_IDLE   = 2'd0,
        MA_ACCESS = 2'd1,
        MA_DONE   = 2'd2
    } ma_state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_M = 1'b1
    } ma_owner_e;

    localparam int unsigned MA_MEM_BYTES_DEF = 8192;
    localparam int unsigned MA_TIMEOUT_DEF   = 15;

endpackage

// File: rtl/mem_addr_chk.sv
// Combinational request legality check: the 8-byte word must lie inside memory
// and a request may not be both a read and a write.
module mem_addr_chk
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MA_MEM_BYTES_DEF
) (
    input  qword_t addr_i,
    input  logic   rd_i,
    input  logic   wr_i,
    output logic   ok_o
);

    // Comparing against the last legal base avoids the wrap of addr+7 near 2^64.
    localparam qword_t LAST_WORD = qword_t'(MEM_BYTES) - 64'd8;

    // Legality of the presented request
    always_comb begin
        ok_o = !(rd_i && wr_i) && (addr_i <= LAST_WORD);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one memory port between fetch and data requesters;
// the data port has fixed priority and every access is bounded by a timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MA_MEM_BYTES_DEF,
    parameter int unsigned TIMEOUT   = MA_TIMEOUT_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   f_req,
    input  qword_t f_addr,
    output logic   f_done,
    output qword_t f_rdata,
    output logic   f_err,
    input  logic   m_read,
    input  logic   m_write,
    input  qword_t m_addr,
    input  qword_t m_wdata,
    output logic   m_done,
    output qword_t m_rdata,
    output logic   m_err,
    output logic   mem_en,
    output logic   mem_we,
    output qword_t mem_addr,
    output qword_t mem_wdata,
    input  qword_t mem_rdata,
    input  logic   mem_ready,
    output logic   busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    ma_state_e        state_q, state_d;
    ma_owner_e        owner_q, owner_d;
    qword_t           addr_q, addr_d;
    qword_t           wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    qword_t           resp_rdata_s;

    logic   f_done_q, f_done_d, f_err_q, f_err_d;
    logic   m_done_q, m_done_d, m_err_q, m_err_d;
    qword_t f_rdata_q, f_rdata_d, m_rdata_q, m_rdata_d;
    logic   mem_en_q, mem_en_d, mem_we_q, mem_we_d, busy_q, busy_d;

    logic   m_sel_s, req_any_s, win_rd_s, win_wr_s, addr_ok_s;
    qword_t win_addr_s;

    // Winner selection: any data request beats fetch
    always_comb begin
        m_sel_s    = m_read || m_write;
        req_any_s  = m_sel_s || f_req;
        win_addr_s = m_sel_s ? m_addr : f_addr;
        win_rd_s   = m_sel_s ? m_read : 1'b1;
        win_wr_s   = m_sel_s ? m_write : 1'b0;
    end

    mem_addr_chk #(
        .MEM_BYTES (MEM_BYTES)
    ) u_chk (
        .addr_i (win_addr_s),
        .rd_i   (win_rd_s),
        .wr_i   (win_wr_s),
        .ok_o   (addr_ok_s)
    );

    // State and latched-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MA_IDLE;
            owner_q <= OWN_F;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; ready is checked before the timeout so a late ready still succeeds
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        resp_rdata_s = 64'd0;
        case (state_q)
            MA_IDLE: begin
                if (req_any_s) begin
                    owner_d = m_sel_s ? OWN_M : OWN_F;
                    if (!addr_ok_s) begin
                        err_d   = 1'b1;
                        state_d = MA_DONE;
                    end else begin
                        addr_d  = win_addr_s;
                        wdata_d = m_sel_s ? m_wdata : 64'd0;
                        we_d    = m_sel_s && m_write;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = MA_ACCESS;
                    end
                end else begin
                    state_d = MA_IDLE;
                end
            end
            MA_ACCESS: begin
                if (mem_ready) begin
                    err_d        = 1'b0;
                    resp_rdata_s = we_q ? 64'd0 : mem_rdata;
                    state_d      = MA_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = MA_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MA_DONE: begin
                state_d = MA_IDLE;
            end
            default: begin
                state_d = MA_IDLE;
            end
        endcase
    end

    // Output next values, derived from where the FSM is heading
    always_comb begin
        f_done_d  = (state_d == MA_DONE) && (owner_d == OWN_F);
        m_done_d  = (state_d == MA_DONE) && (owner_d == OWN_M);
        f_err_d   = f_done_d ? err_d : 1'b0;
        m_err_d   = m_done_d ? err_d : 1'b0;
        f_rdata_d = f_done_d ? resp_rdata_s : f_rdata_q;
        m_rdata_d = m_done_d ? resp_rdata_s : m_rdata_q;
        mem_en_d  = (state_d == MA_ACCESS);
        mem_we_d  = (state_d == MA_ACCESS) && we_d;
        busy_d    = (state_d != MA_IDLE);
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_done_q  <= 1'b0;
            f_err_q   <= 1'b0;
            f_rdata_q <= 64'd0;
            m_done_q  <= 1'b0;
            m_err_q   <= 1'b0;
            m_rdata_q <= 64'd0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            f_done_q  <= f_done_d;
            f_err_q   <= f_err_d;
            f_rdata_q <= f_rdata_d;
            m_done_q  <= m_done_d;
            m_err_q   <= m_err_d;
            m_rdata_q <= m_rdata_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            busy_q    <= busy_d;
        end
    end

    assign f_done    = f_done_q;
    assign f_err     = f_err_q;
    assign f_rdata   = f_rdata_q;
    assign m_done    = m_done_q;
    assign m_err     = m_err_q;
    assign m_rdata   = m_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, cycle 0 is the IDLE
// cycle in which the request is presented; outputs are sampled on the falling edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [63:0] f_addr = 64'd0;
    logic        f_done, f_err;
    logic [63:0] f_rdata;
    logic        m_read = 1'b0, m_write = 1'b0;
    logic [63:0] m_addr = 64'd0, m_wdata = 64'd0;
    logic        m_done, m_err;
    logic [63:0] m_rdata;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = 64'd0;
    logic        mem_ready = 1'b0;
    logic        busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_done    (f_done),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .m_read    (m_read),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_done    (m_done),
        .m_rdata   (m_rdata),
        .m_err     (m_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if ({f_done, f_err, m_done, m_err, mem_en, mem_we, busy} !== 7'd0) $display("FAIL reset_flags got %b exp 0000000", {f_done, f_err, m_done, m_err, mem_en, mem_we, busy}); else passed++;
        total++; if ({f_rdata, m_rdata, mem_addr, mem_wdata} !== 256'd0) $display("FAIL reset_data got %h exp 0", {f_rdata, m_rdata, mem_addr, mem_wdata}); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b exp 0", busy); else passed++;
    endtask

    task automatic test_fetch_read();
        @(negedge clk);
        f_req = 1'b1; f_addr = 64'h10;
        @(negedge clk);
        total++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 64'h10}) $display("FAIL fetch_access got en=%b we=%b a=%h exp en=1 we=0 a=10", mem_en, mem_we, mem_addr); else passed++;
        mem_ready = 1'b1; mem_rdata = 64'h1122334455667788;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 64'd0;
        total++; if ({f_done, f_err, m_done} !== 3'b100) $display("FAIL fetch_done got done=%b err=%b m_done=%b exp 1 0 0", f_done, f_err, m_done); else passed++;
        total++; if (f_rdata !== 64'h1122334455667788) $display("FAIL fetch_rdata got %h exp 1122334455667788", f_rdata); else passed++;
        total++; if (mem_en !== 1'b0) $display("FAIL fetch_en_drop got %b exp 0", mem_en); else passed++;
        f_req = 1'b0;
        @(negedge clk);
        total++; if ({f_done, busy} !== 2'b00) $display("FAIL fetch_back_idle got done=%b busy=%b exp 0 0", f_done, busy); else passed++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        f_req = 1'b1; f_addr = 64'h20;
        m_write = 1'b1; m_addr = 64'h100; m_wdata = 64'hAB;
        @(negedge clk);
        total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 64'h100, 64'hAB}) $display("FAIL prio_write_access got en=%b we=%b a=%h d=%h exp 1 1 100 ab", mem_en, mem_we, mem_addr, mem_wdata); else passed++;
        mem_ready = 1'b1; mem_rdata = 64'hDEAD;
        @(negedge clk);
        mem_ready = 1'b0;
        total++; if ({m_done, m_err, f_done} !== 3'b100) $display("FAIL prio_m_done got m_done=%b m_err=%b f_done=%b exp 1 0 0", m_done, m_err, f_done); else passed++;
        total++; if (m_rdata !== 64'd0) $display("FAIL prio_write_rdata got %h exp 0", m_rdata); else passed++;
        m_write = 1'b0;
        @(negedge clk);
        total++; if ({busy, mem_en} !== 2'b00) $display("FAIL prio_idle_c3 got busy=%b en=%b exp 0 0", busy, mem_en); else passed++;
        @(negedge clk);
        total++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 64'h20}) $display("FAIL prio_fetch_access got en=%b we=%b a=%h exp 1 0 20", mem_en, mem_we, mem_addr); else passed++;
        mem_ready = 1'b1; mem_rdata = 64'hCAFE;
        @(negedge clk);
        mem_ready = 1'b0;
        total++; if ({f_done, f_err, f_rdata} !== {1'b1, 1'b0, 64'hCAFE}) $display("FAIL prio_f_done_c5 got done=%b err=%b d=%h exp 1 0 cafe", f_done, f_err, f_rdata); else passed++;
        f_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_range();
        logic [63:0] bad_addr [2];
        bad_addr[0] = 64'd8185;
        bad_addr[1] = 64'hFFFFFFFFFFFFFFFC;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m_read = 1'b1; m_addr = bad_addr[i];
            @(negedge clk);
            total++; if ({m_done, m_err, mem_en} !== 3'b110) $display("FAIL range_bad%0d got done=%b err=%b en=%b exp 1 1 0", i, m_done, m_err, mem_en); else passed++;
            m_read = 1'b0;
            @(negedge clk);
            total++; if ({m_done, mem_en, busy} !== 3'b000) $display("FAIL range_bad%0d_after got done=%b en=%b busy=%b exp 0 0 0", i, m_done, mem_en, busy); else passed++;
        end
        @(negedge clk);
        m_read = 1'b1; m_addr = 64'd8184;
        @(negedge clk);
        total++; if ({mem_en, mem_addr} !== {1'b1, 64'd8184}) $display("FAIL range_last_access got en=%b a=%h exp 1 1ff8", mem_en, mem_addr); else passed++;
        mem_ready = 1'b1; mem_rdata = 64'h55AA;
        @(negedge clk);
        mem_ready = 1'b0;
        total++; if ({m_done, m_err, m_rdata} !== {1'b1, 1'b0, 64'h55AA}) $display("FAIL range_last_done got done=%b err=%b d=%h exp 1 0 55aa", m_done, m_err, m_rdata); else passed++;
        m_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int en_cycles;
        int early_done;
        for (int pass = 0; pass < 2; pass++) begin
            en_cycles = 0; early_done = 0;
            @(negedge clk);
            f_req = 1'b1; f_addr = 64'h40;
            for (int c = 1; c <= 15; c++) begin
                @(negedge clk);
                if (mem_en === 1'b1) en_cycles++;
                if (f_done !== 1'b0) early_done++;
                if (pass == 1 && c == 15) begin
                    mem_ready = 1'b1; mem_rdata = 64'h0F0F;
                end
            end
            @(negedge clk);
            mem_ready = 1'b0;
            total++; if ({en_cycles, early_done} !== {32'd15, 32'd0}) $display("FAIL timeout%0d_window got en=%0d early=%0d exp 15 0", pass, en_cycles, early_done); else passed++;
            total++; if ({f_done, f_err, mem_en} !== {1'b1, (pass == 0), 1'b0}) $display("FAIL timeout%0d_c16 got done=%b err=%b en=%b exp 1 %0d 0", pass, f_done, f_err, mem_en, (pass == 0)); else passed++;
            if (pass == 1) begin
                total++; if (f_rdata !== 64'h0F0F) $display("FAIL timeout_late_rdata got %h exp f0f", f_rdata); else passed++;
            end
            f_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        m_read = 1'b1; m_write = 1'b1; m_addr = 64'h80;
        @(negedge clk);
        total++; if ({m_done, m_err, mem_en, f_done} !== 4'b1100) $display("FAIL illegal got done=%b err=%b en=%b f_done=%b exp 1 1 0 0", m_done, m_err, mem_en, f_done); else passed++;
        m_read = 1'b0; m_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        @(negedge clk);
        f_req = 1'b1; f_addr = 64'h200;
        @(negedge clk);
        total++; if (mem_en !== 1'b1) $display("FAIL rstmid_access got en=%b exp 1", mem_en); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if ({mem_en, busy} !== 2'b00) $display("FAIL rstmid_async got en=%b busy=%b exp 0 0", mem_en, busy); else passed++;
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (f_done !== 1'b0 || mem_en !== 1'b0) stray++;
        end
        mem_ready = 1'b0;
        total++; if (stray !== 0) $display("FAIL rstmid_no_done got %0d bad cycles exp 0", stray); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if ({mem_en, mem_addr} !== {1'b1, 64'h200}) $display("FAIL rstmid_fresh_access got en=%b a=%h exp 1 200", mem_en, mem_addr); else passed++;
        mem_ready = 1'b1; mem_rdata = 64'h77;
        @(negedge clk);
        mem_ready = 1'b0;
        total++; if ({f_done, f_err, f_rdata} !== {1'b1, 1'b0, 64'h77}) $display("FAIL rstmid_fresh_done got done=%b err=%b d=%h exp 1 0 77", f_done, f_err, f_rdata); else passed++;
        f_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_back_to_back();
        test_range();
        test_timeout();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d/%0d checks", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the CPU's single unified memory port. Fetch (instruction) and memory-stage (data) requests share it. The block grants one requester at a time and drives a variable-latency memory with an enable/ready handshake. It returns read data plus an error flag that feeds the pipeline's `imem_err`/`dmem_err` status logic. It sits between the fetch and memory stages and the memory model.

## Interface
Parameters:
- `MEM_BYTES`, 8192: memory size in bytes; valid word address range is 0..MEM_BYTES-8.
- `TIMEOUT`, 15: maximum cycles to wait for `mem_ready`; width of the wait counter is $clog2(TIMEOUT+1).

Ports (`QWORD` = [63:0]):
- `clk`, in, 1: single clock; all state on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `f_req`, in, 1: fetch read request (level, held until `f_done`).
- `f_addr`, in, `QWORD`: fetch address.
- `f_done`, out, 1: one-cycle completion pulse for fetch.
- `f_rdata`, out, `QWORD`: fetch read data, valid with `f_done`.
- `f_err`, out, 1: fetch error, valid with `f_done`.
- `m_read`, in, 1: data read request (level, held until `m_done`).
- `m_write`, in, 1: data write request (level, held until `m_done`).
- `m_addr`, in, `QWORD`: data address.
- `m_wdata`, in, `QWORD`: write data.
- `m_done`, out, 1: one-cycle completion pulse for data.
- `m_rdata`, out, `QWORD`: data read result, valid with `m_done`.
- `m_err`, out, 1: data error, valid with `m_done`.
- `mem_en`, out, 1: memory access active.
- `mem_we`, out, 1: write when high.
- `mem_addr`, out, `QWORD`: memory address.
- `mem_wdata`, out, `QWORD`: memory write data.
- `mem_rdata`, in, `QWORD`: memory read data, valid with `mem_ready`.
- `mem_ready`, in, 1: memory completes the access this cycle.
- `busy`, out, 1: high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE. Registers: `owner` (F/M), latched `addr`/`wdata`/`we`, `err`, wait counter.
- **IDLE, winner selection:** the data port wins when `m_read|m_write` is high, regardless of `f_req`. The data port has fixed priority because the M-stage instruction is older. Otherwise fetch wins if `f_req` is high. With no request, stay in IDLE.
- **IDLE, checks on the winner:**
  - Illegal: `m_read & m_write` both high. Go to DONE with `err=1`; no memory access.
  - Out of range: `addr > MEM_BYTES-8`, compared at full 64-bit width unsigned. This covers addresses near 2^64 whose +7 would wrap. Go to DONE with `err=1`; no memory access.
  - Otherwise: latch `addr`, `wdata`, `we`, `owner`; clear the counter; go to ACCESS.
- **ACCESS:**
  - `mem_en=1`; `mem_we`, `mem_addr`, `mem_wdata` come from the latched registers and are stable throughout.
  - On `mem_ready=1`: capture `mem_rdata` (reads only), set `err=0`, go to DONE.
  - Else, if the counter equals TIMEOUT-1: set `err=1` and go to DONE. `mem_en` is low from the next cycle.
  - Else: increment the counter.
- **DONE:** pulse the owner's `x_done` with `x_rdata`/`x_err`, then go to IDLE. No request is sampled in DONE. The requester drops or changes its request in the cycle after `x_done`.
- **Write responses:** `x_rdata` holds 0.
- **Non-owner outputs:** the non-owner's `done` stays 0.
- **Starvation:** a pending fetch waits as long as the data port requests. This is acceptable, because the M stage stalls fetch anyway.

## Timing
- All outputs are registered.
- **Reset values:** `f_done`, `f_rdata`, `f_err`, `m_done`, `m_rdata`, `m_err`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `busy` are all 0. State = IDLE, counter = 0.
- **Reset mid-access:** `mem_en` drops immediately (asynchronous). The access is abandoned and no `done` pulse is issued.
- **Latency**, from the request seen in IDLE at cycle 0:
  - `mem_en` rises at cycle 1.
  - If `mem_ready` arrives at cycle 1+k, `done` pulses at cycle 2+k.
  - Minimum is 3 cycles per access (IDLE, ACCESS, DONE).
- **Error latency:**
  - Illegal/out-of-range request: `done`+`err` at cycle 1.
  - Timeout: `done`+`err` at cycle TIMEOUT+1.
- **Late ready:** `mem_ready` arriving in the same cycle as the timeout decision counts as success (ready takes precedence).
- **Stray ready:** `mem_ready` outside ACCESS is ignored.

## Structure
- **Shared `defines.vh`** gains: the state encodings (`MA_IDLE`, `MA_ACCESS`, `MA_DONE`), the owner encodings, and the default `MEM_BYTES`/`TIMEOUT`. `QWORD` is reused.
- **Sub-module:** one natural sub-module, `mem_addr_chk`. It is combinational: address plus read/write flags in, `ok` out. The arbiter uses it now and the memory model can reuse it later.

## Test plan
- **Fetch read:** `f_req=1`, `f_addr=0x10`; memory answers `mem_ready` on the first ACCESS cycle with `0x1122334455667788` -> `mem_en` cycle 1, `f_done=1` cycle 2, `f_rdata=0x1122334455667788`, `f_err=0`.
- **Simultaneous requests:** `f_req` plus `m_write` (`m_addr=0x100`, `m_wdata=0xAB`) at the same time -> data is served first with `mem_we=1`, `mem_addr=0x100`, `m_done` at cycle 2. Fetch is granted in the IDLE at cycle 3; `f_done` at cycle 5.
- **Range limits:** `m_read`, `m_addr=MEM_BYTES-7` -> `m_done=1`, `m_err=1` at cycle 1, `mem_en` never high. `m_addr=0xFFFFFFFFFFFFFFFC` gives the same result. `m_addr=MEM_BYTES-8` succeeds.
- **Timeout vs ready:**
  - `mem_ready` held 0 -> `f_done`+`f_err` at cycle 16 (TIMEOUT=15); `mem_en` high for cycles 1..15.
  - `mem_ready` pulsed at cycle 15 -> success, `f_err=0`.
- **Illegal request:** `m_read=m_write=1` -> `m_err=1` at cycle 1, no memory access.
- **Reset mid-access:** `rst_n` low during ACCESS -> `mem_en` drops without waiting for a clock edge; no `done` pulse. After release, a fresh `f_req` completes normally.
